// File: rtl/sig_chk_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the loopback half-period checker.
package sig_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    LOCKING = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  localparam int CNT_W_DEF = 18;
  localparam int ERR_W_DEF = 16;

  // Nominal half-period in SYSCLK cycles for a given speed setting.
  function automatic logic [31:0] exp_half(input logic [3:0] speedctr);
    return 32'd1 << speedctr;
  endfunction

endpackage

// File: rtl/sig_sync_edge.sv
`timescale 1ns/1ps
// Multi-flop synchronizer for the returned test signal plus a both-edges detector.
module sig_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic sync_level_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_level_o = sync_q[SYNC_STAGES-1];
  assign edge_o       = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/sig_period_checker.sv
`timescale 1ns/1ps
// Receive-side half-period checker: measures run lengths between edges of the
// returned test signal and tracks lock against the 2^SPEEDCTR expectation.
module sig_period_checker
  import sig_chk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TOL         = 1,
  parameter int LOCK_COUNT  = 8,
  parameter int TIMEOUT     = 131072,
  parameter int ERR_W       = ERR_W_DEF
) (
  input  logic             SYSCLK,
  input  logic             G_RST,
  input  logic [3:0]       SPEEDCTR,
  input  logic             sig_in,
  output logic             locked,
  output logic             sig_lost,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] last_half,
  output logic             meas_valid
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] RUN_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [GW-1:0]    G_ONE     = GW'(1);
  localparam logic [GW-1:0]    LOCK_C    = GW'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  logic             edge_det;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] exp_q;
  logic [3:0]       spd_q, spd_prev_q;
  logic [1:0]       spd_vld_q;
  state_e           state_q, state_d;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] last_half_q, last_half_d;
  logic             sig_lost_q, sig_lost_d;
  logic             meas_valid_q, meas_valid_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q;
  logic [CNT_W-1:0] lo_lim, hi_lim;
  logic             good_run, timeout, spd_chg;

  // Only the edge strobe drives the measurement; the level output is left open.
  sig_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i       (SYSCLK),
    .rst_i       (G_RST),
    .sig_i       (sig_in),
    .sync_level_o(),
    .edge_o      (edge_det)
  );

  assign lo_lim   = (exp_q > TOL_C) ? (exp_q - TOL_C) : '0;
  assign hi_lim   = exp_q + TOL_C;
  assign good_run = (run_q >= lo_lim) && (run_q <= hi_lim);
  assign timeout  = (state_q != IDLE) && (run_q >= TIMEOUT_C);
  // The two-deep valid pipe keeps the post-reset load of spd_q from looking like a change.
  assign spd_chg  = spd_vld_q[1] && (spd_q != spd_prev_q);
  assign good_inc = good_q + G_ONE;

  always_comb begin
    run_d = run_q;
    if (edge_det)               run_d = RUN_ONE;
    else if (run_q != RUN_MAX)  run_d = run_q + RUN_ONE;
  end

  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    err_cnt_d    = err_cnt_q;
    last_half_d  = last_half_q;
    sig_lost_d   = sig_lost_q;
    meas_valid_d = 1'b0;
    err_pulse_d  = 1'b0;

    if (edge_det) sig_lost_d = 1'b0;

    if (timeout) begin
      state_d    = IDLE;
      good_d     = '0;
      sig_lost_d = 1'b1;
    end else if (spd_chg) begin
      state_d = IDLE;
      good_d  = '0;
    end else if (edge_det) begin
      if (state_q != IDLE) begin
        meas_valid_d = 1'b1;
        last_half_d  = run_q;
      end
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (good_run) begin
            good_d  = G_ONE;
            state_d = (G_ONE >= LOCK_C) ? LOCKED : LOCKING;
          end
        end
        LOCKING: begin
          if (good_run) begin
            good_d = good_inc;
            if (good_inc >= LOCK_C) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (!good_run) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_ONE;
            good_d  = '0;
            state_d = LOCKING;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (G_RST) begin
      run_q        <= '0;
      exp_q        <= '0;
      spd_q        <= '0;
      spd_prev_q   <= '0;
      spd_vld_q    <= '0;
      state_q      <= IDLE;
      good_q       <= '0;
      err_cnt_q    <= '0;
      last_half_q  <= '0;
      sig_lost_q   <= 1'b0;
      meas_valid_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      run_q        <= run_d;
      exp_q        <= CNT_W'(exp_half(SPEEDCTR));
      spd_q        <= SPEEDCTR;
      spd_prev_q   <= spd_q;
      spd_vld_q    <= {spd_vld_q[0], 1'b1};
      state_q      <= state_d;
      good_q       <= good_d;
      err_cnt_q    <= err_cnt_d;
      last_half_q  <= last_half_d;
      sig_lost_q   <= sig_lost_d;
      meas_valid_q <= meas_valid_d;
      err_pulse_q  <= err_pulse_d;
      locked_q     <= (state_d == LOCKED);
    end
  end

  assign locked     = locked_q;
  assign sig_lost   = sig_lost_q;
  assign err_pulse  = err_pulse_q;
  assign err_cnt    = err_cnt_q;
  assign last_half  = last_half_q;
  assign meas_valid = meas_valid_q;

endmodule

// File: tb/tb_sig_period_checker.sv
`timescale 1ns/1ps
// Scoreboard bench for sig_period_checker: directed half-period vectors push
// hand-computed measurement results; a negedge monitor checks each meas_valid.
module tb_sig_period_checker;

  localparam int CNT_W      = 18;
  localparam int ERR_W      = 16;
  localparam int TIMEOUT_TB = 1024;

  logic             SYSCLK = 1'b0;
  logic             G_RST;
  logic [3:0]       SPEEDCTR;
  logic             sig_in;
  logic             locked;
  logic             sig_lost;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic [CNT_W-1:0] last_half;
  logic             meas_valid;

  typedef struct {
    int half;
    bit lck;
    bit err;
    int cnt;
  } meas_t;

  meas_t sbQ[$];
  meas_t cur;
  int    testsRun    = 0;
  int    testsFailed = 0;

  sig_period_checker #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W),
    .TOL        (1),
    .LOCK_COUNT (8),
    .TIMEOUT    (TIMEOUT_TB),
    .ERR_W      (ERR_W)
  ) dut (
    .SYSCLK    (SYSCLK),
    .G_RST     (G_RST),
    .SPEEDCTR  (SPEEDCTR),
    .sig_in    (sig_in),
    .locked    (locked),
    .sig_lost  (sig_lost),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .last_half (last_half),
    .meas_valid(meas_valid)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitTicks(input int n);
    repeat (n) @(posedge SYSCLK);
    #1;
  endtask

  // Toggle sig_in after waitN cycles; queue the measurement that toggle should produce.
  task automatic applyStimulus(input int waitN, input bit expMeas, input int expHalf,
                               input bit expLocked, input bit expErr, input int expCnt);
    meas_t m;
    repeat (waitN) @(posedge SYSCLK);
    #1 sig_in = ~sig_in;
    if (expMeas) begin
      m.half = expHalf;
      m.lck  = expLocked;
      m.err  = expErr;
      m.cnt  = expCnt;
      sbQ.push_back(m);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_locked"},     locked,     0);
    checkOutput({tag, "_sig_lost"},   sig_lost,   0);
    checkOutput({tag, "_err_pulse"},  err_pulse,  0);
    checkOutput({tag, "_err_cnt"},    err_cnt,    0);
    checkOutput({tag, "_last_half"},  last_half,  0);
    checkOutput({tag, "_meas_valid"}, meas_valid, 0);
  endtask

  always @(negedge SYSCLK) begin
    if (meas_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_meas: got last_half %0d, expected no measurement", last_half);
      end else begin
        cur = sbQ.pop_front();
        checkOutput("meas_last_half", last_half, cur.half);
        checkOutput("meas_locked",    locked,    cur.lck);
        checkOutput("meas_err_pulse", err_pulse, cur.err);
        checkOutput("meas_err_cnt",   err_cnt,   cur.cnt);
      end
    end else if (err_pulse === 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL stray_err_pulse: got err_pulse 1 without meas_valid, expected 0");
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    testsFailed++;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    G_RST    = 1'b1;
    SPEEDCTR = 4'd5;
    sig_in   = 1'b0;
    #990;
    checkAllZero("reset");
    #10;
    G_RST = 1'b0;
    $display("[TB] reset released, SPEEDCTR=5");

    applyStimulus(32, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(32, 1, 32, (i == 7), 0, 0);
    waitTicks(5);
    checkOutput("locked_after_9_edges", locked, 1);
    checkOutput("err_cnt_clean", err_cnt, 0);

    $display("[TB] injecting 40-cycle half-period");
    applyStimulus(35, 1, 40, 0, 1, 1);
    for (int i = 0; i < 8; i++) applyStimulus(32, 1, 32, (i == 7), 0, 1);

    $display("[TB] tolerance edges 31/33 then 34");
    applyStimulus(31, 1, 31, 1, 0, 1);
    applyStimulus(33, 1, 33, 1, 0, 1);
    applyStimulus(31, 1, 31, 1, 0, 1);
    applyStimulus(33, 1, 33, 1, 0, 1);
    applyStimulus(34, 1, 34, 0, 1, 2);
    for (int i = 0; i < 8; i++) applyStimulus(32, 1, 32, (i == 7), 0, 2);

    $display("[TB] holding sig_in for timeout");
    waitTicks(TIMEOUT_TB + 20);
    checkOutput("timeout_sig_lost", sig_lost, 1);
    checkOutput("timeout_locked", locked, 0);
    checkOutput("timeout_err_cnt", err_cnt, 2);
    checkOutput("timeout_last_half_kept", last_half, 32);
    applyStimulus(1, 0, 0, 0, 0, 2);
    waitTicks(5);
    checkOutput("edge_clears_sig_lost", sig_lost, 0);
    applyStimulus(27, 1, 32, 0, 0, 2);
    for (int i = 0; i < 7; i++) applyStimulus(32, 1, 32, (i == 6), 0, 2);

    $display("[TB] SPEEDCTR 5 -> 3");
    waitTicks(5);
    checkOutput("locked_before_speed_change", locked, 1);
    SPEEDCTR = 4'd3;
    waitTicks(2);
    checkOutput("speed_change_unlocks", locked, 0);
    checkOutput("speed_change_err_cnt_kept", err_cnt, 2);
    applyStimulus(8, 0, 0, 0, 0, 2);
    for (int i = 0; i < 8; i++) applyStimulus(8, 1, 8, (i == 7), 0, 2);

    applyStimulus(12, 1, 12, 0, 1, 3);
    for (int i = 0; i < 3; i++) applyStimulus(8, 1, 8, 0, 0, 3);
    waitTicks(5);
    checkOutput("err_cnt_before_reset", err_cnt, 3);
    checkOutput("queue_drained_before_reset", sbQ.size(), 0);

    $display("[TB] mid-run reset, then SPEEDCTR=0");
    G_RST    = 1'b1;
    SPEEDCTR = 4'd0;
    sig_in   = 1'b0;
    waitTicks(1);
    G_RST = 1'b0;
    checkAllZero("midrun_reset");

    applyStimulus(3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 1, (i == 7), 0, 0);
    waitTicks(5);
    checkOutput("speed0_locked", locked, 1);
    checkOutput("speed0_err_cnt", err_cnt, 0);
    checkOutput("speed0_sig_lost", sig_lost, 0);

    waitTicks(10);
    checkOutput("scoreboard_drained", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
